cyclic_decoder_systematic: RTL and testbench

//  Serial single-error-correcting decoder for the systematic cyclic (Hamming) code produced by the encoder stage.
//  - Accepts one received codeword bit per accepted cycle.
//  - Computes the syndrome with an LFSR divider and corrects at most one bit by syndrome-to-position mapping.
//  - Streams the K corrected data bits out serially with a ready/valid handshake.
//  - Sits downstream of the encoder and channel, and upstream of the data sink.

---
 rtl/cyclic_decoder_systematic.sv | 135 +++++++++++++
 tb/tb_cyclic_decoder_systematic.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cyclic_decoder_systematic.sv
// Serial single-error-correcting decoder for a systematic cyclic (Hamming) code.
// Codeword bits arrive MSB first; an LFSR divider forms the syndrome, which is
// mapped to the error position through a table built at elaboration. Corrected
// data bits stream out MSB first. The input side and the output side are
// double buffered so a continuous input stream never stalls.
module cyclic_decoder_systematic #(
  parameter int         M        = 4,
  parameter logic [M:0] GEN_POLY = 5'b10011
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in,
  output logic          in_ready,
  output logic          out_valid,
  output logic          out,
  input  logic          out_ready,
  output logic          out_last,
  output logic          err_flag,
  output logic [M-1:0]  err_pos,
  output logic [15:0]   corr_count
);
  localparam int N = 2**M - 1;
  localparam int K = N - M;

  typedef enum logic {RECV, FULL} state_t;

  // Syndrome -> bit position table: entry x^p mod g holds p.
  function automatic logic [2**M-1:0][M-1:0] build_pos_map();
    logic [2**M-1:0][M-1:0] map;
    logic [M-1:0]           pw;
    map = '0;
    pw  = {{(M-1){1'b0}}, 1'b1};
    for (int p = 0; p < N; p++) begin
      map[pw] = p[M-1:0];
      pw = pw[M-1] ? ({pw[M-2:0], 1'b0} ^ GEN_POLY[M-1:0]) : {pw[M-2:0], 1'b0};
    end
    return map;
  endfunction

  localparam logic [2**M-1:0][M-1:0] POS_MAP = build_pos_map();

  state_t         state;
  logic [M-1:0]   rx_cnt;
  logic [M-1:0]   syn;
  logic [N-1:0]   in_sr;
  logic [K-1:0]   out_sr;
  logic [M-1:0]   out_cnt;

  logic           accept;
  logic           word_done;
  logic           out_free;
  logic           xfer;
  logic [M-1:0]   syn_step;
  logic [N-1:0]   sr_step;
  logic [M-1:0]   src_syn;
  logic [K-1:0]   src_data;
  logic [M-1:0]   src_pos;
  logic           has_err;
  logic [K-1:0]   fixed_data;

  assign in_ready  = (state == RECV);
  assign out       = out_sr[K-1];
  assign out_last  = out_valid && (out_cnt == M'(K-1));

  // Next-state of the divider and input register, and the transfer decision.
  // When the N-th bit lands while the output register is free, the word is
  // transferred on that same edge so the input side never has to stall.
  always_comb begin
    accept    = in_valid && in_ready;
    syn_step  = {syn[M-2:0], in} ^ (syn[M-1] ? GEN_POLY[M-1:0] : '0);
    sr_step   = {in_sr[N-2:0], in};
    word_done = accept && (rx_cnt == M'(N-1));
    out_free  = !out_valid || (out_last && out_ready);
    xfer      = out_free && ((state == FULL) || word_done);
    src_syn   = (state == FULL) ? syn : syn_step;
    src_data  = (state == FULL) ? in_sr[N-1:M] : sr_step[N-1:M];
    src_pos   = POS_MAP[src_syn];
    has_err   = (src_syn != '0);
  end

  // Flip the data bit whose codeword index matches the syndrome position.
  always_comb begin
    fixed_data = '0;
    for (int i = 0; i < K; i++)
      fixed_data[i] = src_data[i] ^ (has_err && (src_pos == M'(i + M)));
  end

  // Input FSM: collect N bits, hold them in FULL until the output side frees.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RECV;
      rx_cnt <= '0;
      syn    <= '0;
      in_sr  <= '0;
    end else begin
      if (accept) begin
        in_sr  <= sr_step;
        syn    <= syn_step;
        rx_cnt <= word_done ? '0 : rx_cnt + 1'b1;
        if (word_done && !xfer) state <= FULL;
      end
      if (xfer) begin
        syn   <= '0;
        state <= RECV;
      end
    end
  end

  // Output side: load corrected word on transfer, then shift out K bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_sr     <= '0;
      out_cnt    <= '0;
      err_flag   <= 1'b0;
      err_pos    <= '0;
      corr_count <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_sr    <= fixed_data;
      out_cnt   <= '0;
      err_flag  <= has_err;
      err_pos   <= has_err ? src_pos : '0;
      if (has_err && corr_count != 16'hFFFF) corr_count <= corr_count + 16'd1;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        out_valid <= 1'b0;
      end else begin
        out_sr  <= {out_sr[K-2:0], 1'b0};
        out_cnt <= out_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cyclic_decoder_systematic.sv
// Directed bench for the serial cyclic decoder: a vector table of codewords
// with hand-derived data/error expectations, plus hand-written sequences for
// back-to-back streaming, output back-pressure and mid-word reset.
module tb_cyclic_decoder_systematic;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        din;
  logic        in_ready;
  logic        out_valid;
  logic        dout;
  logic        out_ready;
  logic        out_last;
  logic        err_flag;
  logic [3:0]  err_pos;
  logic [15:0] corr_count;

  int checks = 0;
  int errors = 0;

  cyclic_decoder_systematic dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .in_ready(in_ready),
    .out_valid(out_valid), .out(dout), .out_ready(out_ready), .out_last(out_last),
    .err_flag(err_flag), .err_pos(err_pos), .corr_count(corr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] cw;
    logic [10:0] data;
    logic        err;
    logic [3:0]  pos;
    logic        rst_before;
  } vec_t;

  vec_t vecs[23];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Present nbits of cw, MSB first, waiting (bounded) for in_ready.
  task automatic send_bits(input logic [14:0] cw, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int t;
      t = 0;
      din = cw[14-i]; in_valid = 1'b1;
      while (!in_ready && t < 200) begin step(); t++; end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      step();
    end
    in_valid = 1'b0;
  endtask

  // Collect K bits; with nogap every bit must be valid without waiting.
  task automatic recv_word(output logic [10:0] d, output logic e, output logic [3:0] p,
                           input logic nogap);
    d = '0; e = 1'b0; p = '0;
    for (int i = 0; i < 11; i++) begin
      int t;
      t = 0;
      if (nogap) chk("no_gap", out_valid, 1);
      while (!out_valid && t < 200) begin step(); t++; end
      if (!out_valid) chk("out_valid_timeout", 0, 1);
      d = {d[9:0], dout};
      if (i == 0) begin e = err_flag; p = err_pos; end
      chk("out_last", out_last, (i == 10));
      step();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] d;
    logic        e;
    logic [3:0]  p;
    int          exp_corr;
    logic [14:0] words[4];
    logic [10:0] wdata[4];

    vecs[0] = '{15'h0000, 11'h000, 1'b0, 4'd0,  1'b0};
    vecs[1] = '{15'h0013, 11'h001, 1'b0, 4'd0,  1'b0};
    vecs[2] = '{15'h0093, 11'h001, 1'b1, 4'd7,  1'b0};
    vecs[3] = '{15'h4009, 11'h400, 1'b0, 4'd0,  1'b0};
    vecs[4] = '{15'h0407, 11'h040, 1'b0, 4'd0,  1'b0};
    vecs[5] = '{15'h441D, 11'h441, 1'b0, 4'd0,  1'b0};
    vecs[6] = '{15'h541D, 11'h441, 1'b1, 4'd12, 1'b0};
    vecs[7] = '{15'h4029, 11'h400, 1'b1, 4'd5,  1'b0};
    for (int i = 0; i < 15; i++)
      vecs[8+i] = '{15'h0013 ^ (15'h0001 << i), 11'h001, 1'b1, 4'(i), (i == 0)};

    reset = 1'b1; in_valid = 1'b0; din = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", dout, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_pos", err_pos, 0);
    chk("rst_corr_count", corr_count, 0);

    // Table: single words, out_ready held high.
    out_ready = 1'b1;
    exp_corr = 0;
    foreach (vecs[i]) begin
      if (vecs[i].rst_before) begin do_reset(); exp_corr = 0; end
      send_bits(vecs[i].cw, 15);
      chk("latency", out_valid, 1);
      recv_word(d, e, p, 1'b0);
      if (vecs[i].err) exp_corr++;
      chk($sformatf("data[%0d]", i), d, vecs[i].data);
      chk($sformatf("err_flag[%0d]", i), e, vecs[i].err);
      chk($sformatf("err_pos[%0d]", i), p, vecs[i].pos);
      chk($sformatf("corr_count[%0d]", i), corr_count, exp_corr);
    end
    chk("corr_count_15", corr_count, 15);

    // Back-to-back stream of 4 words: input never stalls, 44 bits out.
    words = '{15'h0013, 15'h4009, 15'h0407, 15'h541D};
    wdata = '{11'h001, 11'h400, 11'h040, 11'h441};
    fork
      begin
        for (int w = 0; w < 4; w++)
          for (int b = 0; b < 15; b++) begin
            din = words[w][14-b]; in_valid = 1'b1;
            chk("stream_in_ready", in_ready, 1);
            step();
          end
        in_valid = 1'b0;
      end
      begin
        for (int w = 0; w < 4; w++) begin
          logic [10:0] sd;
          logic        se;
          logic [3:0]  sp;
          recv_word(sd, se, sp, 1'b0);
          chk($sformatf("stream_data[%0d]", w), sd, wdata[w]);
        end
      end
    join

    // Back-pressure: second word waits in FULL, then follows with no gap.
    do_reset();
    out_ready = 1'b0;
    send_bits(15'h4009, 15);
    chk("bp_out_valid", out_valid, 1);
    send_bits(15'h0013, 15);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_hold", dout, 1);
    step(); step(); step();
    chk("bp_in_ready_still_low", in_ready, 0);
    chk("bp_out_stable", dout, 1);
    chk("bp_valid_stable", out_valid, 1);
    out_ready = 1'b1;
    recv_word(d, e, p, 1'b1);
    chk("bp_word1", d, 11'h400);
    recv_word(d, e, p, 1'b1);
    chk("bp_word2", d, 11'h001);
    chk("bp_in_ready_back", in_ready, 1);
    step();
    chk("bp_out_valid_drop", out_valid, 0);

    // Reset in the middle of both input and output.
    send_bits(15'h541D, 15);
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;
    send_bits(15'h0013, 7);
    chk("mid_err_flag_pre", err_flag, 1);
    do_reset();
    chk("mr_in_ready", in_ready, 1);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out", dout, 0);
    chk("mr_out_last", out_last, 0);
    chk("mr_err_flag", err_flag, 0);
    chk("mr_err_pos", err_pos, 0);
    chk("mr_corr_count", corr_count, 0);
    out_ready = 1'b1;
    send_bits(15'h0013, 15);
    recv_word(d, e, p, 1'b0);
    chk("mr_data", d, 11'h001);
    chk("mr_err", e, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
